msx_sprite_line_engine: RTL and testbench
=========================================

Name: msx_sprite_line_engine

Overview:
- Parametrised per-scanline sprite engine for the TMS9918-style video path. It replaces the fixed 4-sprite, 8x8-only sprite logic.
- During horizontal blanking it scans the sprite attribute table in VRAM for the next line. It selects up to MAX_PER_LINE sprites, fetches their attributes and pattern rows, then commits them to an active bank.
- During the active line it produces a registered sprite pixel colour, plus sticky collision and 5th-sprite status, for the video mixer and status register.

Parameters:
MAX_PER_LINE, 4, sprites displayed per line (1..8); an extra hit raises the 5th-sprite flag
NUM_SPRITES, 32, attribute table entries scanned (1..32)
VRAM_AW, 14, VRAM address width

Ports:
clk  in  1  pixel clock
n_reset  in  1  asynchronous active-low reset
line_start  in  1  one-cycle pulse; starts evaluation for line next_y
next_y  in  8  line being evaluated (0..191)
sat_addr  in  VRAM_AW  sprite attribute table base
spt_addr  in  VRAM_AW  sprite pattern table base
sprite_large  in  1  0=8x8, 1=16x16
sprite_enlarged  in  1  1=pixel doubling
vram_addr  out  VRAM_AW  read address
vram_rd  out  1  read strobe; vram_data valid the following cycle
vram_data  in  8  read data
x  in  8  current pixel x
pix_en  in  1  x valid (active area)
pixel_color  out  4  sprite colour, 0 if none
pixel_valid  out  1  opaque sprite pixel present
collision  out  1  sticky collision flag
fifth  out  1  sticky too-many-sprites flag
fifth_num  out  5  sprite index for fifth / last scanned
status_clr  in  1  clears collision and fifth
busy  out  1  evaluation in progress

Behaviour:
- Reset (n_reset low, async): state IDLE, every output 0, active sprite count 0, all shadow and active registers 0.
- VRAM reads: one read per 2 cycles. Cycle 0 drives vram_addr and vram_rd=1; cycle 1 captures vram_data with vram_rd=0.
- FSM: IDLE -> SCAN on line_start. busy=1 from the cycle after line_start until re-entering IDLE.
- SCAN, for i=0..NUM_SPRITES-1:
  - Read Y at sat_addr+4i.
  - Y==208 ends the scan.
  - size = (sprite_large?16:8)<<sprite_enlarged.
  - row = (next_y - Y - 1) mod 256, 8-bit wrap. Hit if row<size.
  - Hit with count<MAX_PER_LINE: store i and row in the shadow slot, count++.
  - Hit with count==MAX_PER_LINE: if fifth==0, set fifth and fifth_num=i; end the scan.
  - Scan ends with no overflow and fifth==0: fifth_num = last index read.
  - Worst case 2*NUM_SPRITES cycles.
- FETCH, per slot k in order:
  - Read X (+1), name (+2), colour (+3). Colour bit7 = early clock; bits[3:0] = colour.
  - Then pattern rows, with line = row>>sprite_enlarged:
    - 8x8: one read at spt_addr + name*8 + line[2:0].
    - 16x16: left at spt_addr + (name&0xFC)*8 + line[3:0]; right at that address +16.
  - 8 cycles per slot for 8x8, 10 cycles per slot for 16x16.
- COMMIT (1 cycle): copy shadow to active bank, including count, then IDLE.
- line_start while busy: abort and restart SCAN. The active bank and sticky flags are unchanged.
- Address arithmetic wraps modulo 2^VRAM_AW.
- Pixel path, per active slot with pix_en=1:
  - ex = {0,X} - (early?32:0), 9-bit signed. col = {0,x} - ex.
  - In range if 0<=col<size. Bit = pattern[(col>>sprite_enlarged)], MSB first; 16x16 uses left:right.
  - Priority: lowest slot with a set bit and non-zero colour drives pixel_color, pixel_valid=1.
  - Colour 0 is transparent: no output, but still counts for collision.
  - Registered: outputs appear one cycle after pix_en/x. pix_en=0 gives pixel_color=0 and pixel_valid=0 on the next cycle.
- collision sets when 2 or more slots have a set bit in the same pix_en cycle.
- Sticky flags: collision and fifth hold until status_clr. When a set and status_clr coincide, the set wins.

Test Plan:
- Reset mid-SCAN: assert n_reset low during SCAN -> immediate IDLE, busy=0, pixel_valid=0, vram_rd=0.
- 8x8 basic: sprite0 Y=9, X=20, name=1, colour=0x0F, pattern row0=0x80; line_start with next_y=10 -> reads at sat+0..3 and spt+8; at x=20, pixel_color=15 one cycle later; x=21 -> pixel_valid=0.
- Overflow, MAX_PER_LINE=4: five sprites on one line -> four displayed, fifth=1, fifth_num=4. status_clr -> fifth=0. status_clr coinciding with a new set -> stays 1.
- Terminator: sprite2 Y=208 -> SCAN ends after 3 reads (6 cycles), fifth_num=2, no fetch beyond slot count.
- 16x16 enlarged with early clock: X=10, early=1, pattern 0xFFFF -> opaque for x=0..9 (ex=-22, 32-pixel width); name=0x07 -> addresses use name 0x04.
- Collision and priority: slot0 colour 0 and slot1 colour 5 overlap at one x -> pixel_color=5, collision=1; single-sprite lines leave collision=0.

Source files
------------

// File: rtl/msx_sprite_line_engine_if.sv
// VRAM read port of the sprite engine: address and strobe out, data returned
// on the cycle after the strobe.
interface msx_sprite_line_engine_if #(
    parameter int unsigned AW = 14
);
    logic [AW-1:0] vram_addr;
    logic          vram_rd;
    logic [7:0]    vram_data;

    modport master (output vram_addr, output vram_rd, input vram_data);
    modport slave  (input vram_addr, input vram_rd, output vram_data);
endinterface

// File: rtl/msx_sprite_line_engine.sv
// Per-scanline sprite engine: scans the attribute table and fetches patterns
// during blanking, then renders sprite pixels and status flags on the active line.
module msx_sprite_line_engine #(
    parameter int unsigned MAX_PER_LINE = 4,
    parameter int unsigned NUM_SPRITES  = 32,
    parameter int unsigned VRAM_AW      = 14
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     line_start,
    input  logic [7:0]               next_y,
    input  logic [VRAM_AW-1:0]       sat_addr,
    input  logic [VRAM_AW-1:0]       spt_addr,
    input  logic                     sprite_large,
    input  logic                     sprite_enlarged,
    msx_sprite_line_engine_if.master vram,
    input  logic [7:0]               x,
    input  logic                     pix_en,
    output logic [3:0]               pixel_color,
    output logic                     pixel_valid,
    output logic                     collision,
    output logic                     fifth,
    output logic [4:0]               fifth_num,
    input  logic                     status_clr,
    output logic                     busy
);
    localparam int unsigned CW = $clog2(MAX_PER_LINE + 1);
    localparam int unsigned KW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam logic [7:0]  Y_TERM = 8'd208;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_COMMIT} state_e;

    state_e               state_q, state_d;
    logic                 rd_q, rd_d;
    logic [VRAM_AW-1:0]   addr_q, addr_d;
    logic [4:0]           idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d, act_cnt_q, act_cnt_d;
    logic [KW-1:0]        slot_q, slot_d;
    logic [2:0]           step_q, step_d;
    logic [4:0]           sh_idx_q [MAX_PER_LINE], sh_idx_d [MAX_PER_LINE];
    logic [4:0]           sh_row_q [MAX_PER_LINE], sh_row_d [MAX_PER_LINE];
    logic [7:0]           sh_x_q [MAX_PER_LINE], sh_x_d [MAX_PER_LINE];
    logic [7:0]           sh_name_q [MAX_PER_LINE], sh_name_d [MAX_PER_LINE];
    logic [3:0]           sh_col_q [MAX_PER_LINE], sh_col_d [MAX_PER_LINE];
    logic                 sh_early_q [MAX_PER_LINE], sh_early_d [MAX_PER_LINE];
    logic [15:0]          sh_pat_q [MAX_PER_LINE], sh_pat_d [MAX_PER_LINE];
    logic [7:0]           act_x_q [MAX_PER_LINE], act_x_d [MAX_PER_LINE];
    logic [3:0]           act_col_q [MAX_PER_LINE], act_col_d [MAX_PER_LINE];
    logic                 act_early_q [MAX_PER_LINE], act_early_d [MAX_PER_LINE];
    logic [15:0]          act_pat_q [MAX_PER_LINE], act_pat_d [MAX_PER_LINE];
    logic [3:0]           pix_col_q, pix_col_d;
    logic                 pix_vld_q, pix_vld_d;
    logic                 coll_q, coll_d, fifth_q, fifth_d, busy_q, busy_d;
    logic [4:0]           fifth_num_q, fifth_num_d;

    logic [5:0]           size_c;
    logic [7:0]           row, name_eff;
    logic [4:0]           line;
    logic [VRAM_AW-1:0]   pat_addr;
    logic [CW-1:0]        nxt_slot;
    logic                 end_scan, ovf, fifth_set, slot_done, coll_set;
    logic [8:0]           ex;
    logic [9:0]           col;
    logic [3:0]           bidx, nhit;
    logic                 bit_on, found;

    always_comb size_c = (sprite_large ? 6'd16 : 6'd8) << sprite_enlarged;

    // Evaluation FSM: every read is an issue cycle (rd_q=1) followed by a capture cycle.
    always_comb begin
        state_d = state_q;   rd_d = 1'b0;          addr_d = addr_q;
        idx_d = idx_q;       cnt_d = cnt_q;        slot_d = slot_q;
        step_d = step_q;     act_cnt_d = act_cnt_q;
        sh_idx_d = sh_idx_q; sh_row_d = sh_row_q;  sh_x_d = sh_x_q;
        sh_name_d = sh_name_q; sh_col_d = sh_col_q; sh_early_d = sh_early_q;
        sh_pat_d = sh_pat_q; act_x_d = act_x_q;    act_col_d = act_col_q;
        act_early_d = act_early_q; act_pat_d = act_pat_q;
        fifth_set = 1'b0;    fifth_num_d = fifth_num_q;
        end_scan = 1'b0;     ovf = 1'b0;           slot_done = 1'b0;
        row      = next_y - vram.vram_data - 8'd1;
        line     = sh_row_q[slot_q] >> sprite_enlarged;
        name_eff = sprite_large ? (sh_name_q[slot_q] & 8'hFC) : sh_name_q[slot_q];
        pat_addr = spt_addr + VRAM_AW'({name_eff, 3'b000})
                 + VRAM_AW'(sprite_large ? line[3:0] : {1'b0, line[2:0]});
        nxt_slot = CW'(slot_q) + CW'(1);

        if (line_start) begin
            state_d = S_SCAN; rd_d = 1'b1; addr_d = sat_addr; idx_d = '0; cnt_d = '0;
        end else begin
            unique case (state_q)
                S_SCAN: if (!rd_q) begin
                    if (vram.vram_data == Y_TERM) begin
                        end_scan = 1'b1;
                    end else if (row < {2'b00, size_c}) begin
                        if (cnt_q == CW'(MAX_PER_LINE)) begin
                            ovf = 1'b1; end_scan = 1'b1;
                            if (!fifth_q) begin fifth_set = 1'b1; fifth_num_d = idx_q; end
                        end else begin
                            sh_idx_d[KW'(cnt_q)] = idx_q;
                            sh_row_d[KW'(cnt_q)] = 5'(row);
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (idx_q == 5'(NUM_SPRITES - 1)) end_scan = 1'b1;
                    if (end_scan && !ovf && !fifth_q) fifth_num_d = idx_q;
                    if (!end_scan) begin
                        idx_d = idx_q + 5'd1; rd_d = 1'b1; addr_d = addr_q + VRAM_AW'(4);
                    end else if (cnt_d != '0) begin
                        state_d = S_FETCH; slot_d = '0; step_d = '0; rd_d = 1'b1;
                        addr_d = sat_addr + VRAM_AW'({sh_idx_d[0], 2'b00}) + VRAM_AW'(1);
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
                S_FETCH: if (!rd_q) begin
                    rd_d = 1'b1; addr_d = addr_q + VRAM_AW'(1); step_d = step_q + 3'd1;
                    case (step_q)
                        3'd0: sh_x_d[slot_q] = vram.vram_data;
                        3'd1: sh_name_d[slot_q] = vram.vram_data;
                        3'd2: begin
                            sh_col_d[slot_q]   = vram.vram_data[3:0];
                            sh_early_d[slot_q] = vram.vram_data[7];
                            addr_d = pat_addr;
                        end
                        3'd3: begin
                            sh_pat_d[slot_q] = {vram.vram_data, 8'h00};
                            addr_d = addr_q + VRAM_AW'(16);
                            slot_done = !sprite_large;
                        end
                        default: begin
                            sh_pat_d[slot_q][7:0] = vram.vram_data;
                            slot_done = 1'b1;
                        end
                    endcase
                    if (slot_done) begin
                        step_d = '0;
                        if (nxt_slot < cnt_q) begin
                            slot_d = KW'(nxt_slot);
                            addr_d = sat_addr + VRAM_AW'({sh_idx_q[KW'(nxt_slot)], 2'b00}) + VRAM_AW'(1);
                        end else begin
                            rd_d = 1'b0; state_d = S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    act_x_d = sh_x_q; act_col_d = sh_col_q; act_early_d = sh_early_q;
                    act_pat_d = sh_pat_q; act_cnt_d = cnt_q; state_d = S_IDLE;
                end
                default: ;
            endcase
        end
        busy_d  = (state_d != S_IDLE);
        fifth_d = fifth_set ? 1'b1 : (status_clr ? 1'b0 : fifth_q);
    end

    // Pixel path: lowest opaque slot wins; transparent set bits still collide.
    always_comb begin
        pix_col_d = 4'd0; pix_vld_d = 1'b0; nhit = 4'd0; found = 1'b0;
        ex = '0; col = '0; bidx = '0; bit_on = 1'b0;
        for (int k = 0; k < MAX_PER_LINE; k++) begin
            ex     = {1'b0, act_x_q[k]} - (act_early_q[k] ? 9'd32 : 9'd0);
            col    = {2'b00, x} - {ex[8], ex};
            bidx   = 4'(col >> sprite_enlarged);
            bit_on = (CW'(k) < act_cnt_q) && !col[9] && (col < {4'b0000, size_c})
                     && act_pat_q[k][4'd15 - bidx];
            if (bit_on) begin
                nhit = nhit + 4'd1;
                if (!found && act_col_q[k] != 4'd0) begin
                    found = 1'b1; pix_col_d = act_col_q[k]; pix_vld_d = 1'b1;
                end
            end
        end
        if (!pix_en) begin pix_col_d = 4'd0; pix_vld_d = 1'b0; end
        coll_set = pix_en && (nhit >= 4'd2);
        coll_d   = coll_set ? 1'b1 : (status_clr ? 1'b0 : coll_q);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE; rd_q <= 1'b0; addr_q <= '0; idx_q <= '0;
            cnt_q <= '0; act_cnt_q <= '0; slot_q <= '0; step_q <= '0;
            for (int k = 0; k < MAX_PER_LINE; k++) begin
                sh_idx_q[k] <= '0; sh_row_q[k] <= '0; sh_x_q[k] <= '0; sh_name_q[k] <= '0;
                sh_col_q[k] <= '0; sh_early_q[k] <= 1'b0; sh_pat_q[k] <= '0;
                act_x_q[k] <= '0; act_col_q[k] <= '0; act_early_q[k] <= 1'b0; act_pat_q[k] <= '0;
            end
            pix_col_q <= '0; pix_vld_q <= 1'b0; coll_q <= 1'b0; fifth_q <= 1'b0;
            fifth_num_q <= '0; busy_q <= 1'b0;
        end else begin
            state_q <= state_d; rd_q <= rd_d; addr_q <= addr_d; idx_q <= idx_d;
            cnt_q <= cnt_d; act_cnt_q <= act_cnt_d; slot_q <= slot_d; step_q <= step_d;
            sh_idx_q <= sh_idx_d; sh_row_q <= sh_row_d; sh_x_q <= sh_x_d; sh_name_q <= sh_name_d;
            sh_col_q <= sh_col_d; sh_early_q <= sh_early_d; sh_pat_q <= sh_pat_d;
            act_x_q <= act_x_d; act_col_q <= act_col_d; act_early_q <= act_early_d;
            act_pat_q <= act_pat_d;
            pix_col_q <= pix_col_d; pix_vld_q <= pix_vld_d; coll_q <= coll_d; fifth_q <= fifth_d;
            fifth_num_q <= fifth_num_d; busy_q <= busy_d;
        end
    end

    assign vram.vram_addr = addr_q;
    assign vram.vram_rd   = rd_q;
    assign pixel_color    = pix_col_q;
    assign pixel_valid    = pix_vld_q;
    assign collision      = coll_q;
    assign fifth          = fifth_q;
    assign fifth_num      = fifth_num_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_msx_sprite_line_engine.sv
// Directed bench for msx_sprite_line_engine: behavioural VRAM, read-address log,
// hand-computed expectations for scan, fetch, pixel and status behaviour.
module tb_msx_sprite_line_engine;
    localparam int unsigned AW = 14;
    localparam logic [AW-1:0] SAT = 14'h1B00;
    localparam logic [AW-1:0] SPT = 14'h3800;

    logic          clk = 1'b0;
    logic          n_reset, line_start, sprite_large, sprite_enlarged, pix_en, status_clr;
    logic [7:0]    next_y, x;
    logic [AW-1:0] sat_addr, spt_addr;
    logic [3:0]    pixel_color;
    logic          pixel_valid, collision, fifth, busy;
    logic [4:0]    fifth_num;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_log [$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    msx_sprite_line_engine_if #(.AW(AW)) vif ();

    msx_sprite_line_engine #(.MAX_PER_LINE(4), .NUM_SPRITES(32), .VRAM_AW(AW)) dut (
        .clk(clk), .n_reset(n_reset), .line_start(line_start), .next_y(next_y),
        .sat_addr(sat_addr), .spt_addr(spt_addr), .sprite_large(sprite_large),
        .sprite_enlarged(sprite_enlarged), .vram(vif), .x(x), .pix_en(pix_en),
        .pixel_color(pixel_color), .pixel_valid(pixel_valid), .collision(collision),
        .fifth(fifth), .fifth_num(fifth_num), .status_clr(status_clr), .busy(busy)
    );

    // VRAM: data appears the cycle after the strobe; every strobed address is logged.
    always @(posedge clk) begin
        if (vif.vram_rd) begin
            vif.vram_data <= mem[vif.vram_addr];
            rd_log.push_back(vif.vram_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spr(input int i, input logic [7:0] y, input logic [7:0] xp,
                           input logic [7:0] nm, input logic [7:0] cl);
        mem[int'(SAT) + 4*i]     = y;
        mem[int'(SAT) + 4*i + 1] = xp;
        mem[int'(SAT) + 4*i + 2] = nm;
        mem[int'(SAT) + 4*i + 3] = cl;
    endtask

    task automatic clear_sat();
        for (int i = 0; i < 32; i++) set_spr(i, 8'd208, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic run_line(input logic [7:0] y, output int cyc);
        rd_log.delete();
        next_y = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            tick();
        end
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic chk_reads(input string tag, input logic [AW-1:0] e [$]);
        chk({tag, "_nrd"}, 32'(rd_log.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < rd_log.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 32'(rd_log[i]), 32'(e[i]));
    endtask

    task automatic pix(input logic [7:0] xv, output logic [3:0] c, output logic v);
        x = xv;
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        c = pixel_color;
        v = pixel_valid;
    endtask

    task automatic clr_status();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    int         cyc;
    logic [3:0] c;
    logic       v;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        n_reset = 1'b0; line_start = 1'b0; next_y = 8'd0; x = 8'd0; pix_en = 1'b0;
        status_clr = 1'b0; sprite_large = 1'b0; sprite_enlarged = 1'b0;
        sat_addr = SAT; spt_addr = SPT;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd", 32'(vif.vram_rd), 0);
        chk("rst_addr", 32'(vif.vram_addr), 0);
        chk("rst_pix", 32'({pixel_valid, pixel_color}), 0);
        chk("rst_flags", 32'({collision, fifth, fifth_num}), 0);
        n_reset = 1'b1;
        tick();

        // 8x8 single sprite, terminator at entry 1
        clear_sat();
        set_spr(0, 8'd9, 8'd20, 8'd1, 8'h0F);
        mem[int'(SPT) + 8] = 8'h80;
        run_line(8'd10, cyc);
        chk("basic_cyc", 32'(cyc), 32'd13);
        chk_reads("basic", '{SAT, SAT + 14'd4, SAT + 14'd1, SAT + 14'd2, SAT + 14'd3, SPT + 14'd8});
        chk("basic_fnum", 32'(fifth_num), 32'd1);
        chk("basic_fifth", 32'(fifth), 32'd0);
        pix(8'd20, c, v); chk("basic_x20", 32'({v, c}), 32'h1F);
        pix(8'd21, c, v); chk("basic_x21", 32'({v, c}), 32'h00);
        pix(8'd19, c, v); chk("basic_x19", 32'({v, c}), 32'h00);
        x = 8'd20; pix_en = 1'b0; tick();
        chk("basic_noen", 32'({pixel_valid, pixel_color}), 32'h00);

        // 16x16 enlarged, early clock, name masked to 0x04, row 3 -> line 1
        sprite_large = 1'b1; sprite_enlarged = 1'b1;
        clear_sat();
        set_spr(0, 8'd9, 8'd10, 8'h07, 8'h87);
        mem[int'(SPT) + 'h21] = 8'hFF;
        mem[int'(SPT) + 'h31] = 8'hFF;
        run_line(8'd13, cyc);
        chk("big_cyc", 32'(cyc), 32'd15);
        chk_reads("big", '{SAT, SAT + 14'd4, SAT + 14'd1, SAT + 14'd2, SAT + 14'd3,
                           SPT + 14'h21, SPT + 14'h31});
        pix(8'd0, c, v);  chk("big_x0", 32'({v, c}), 32'h17);
        pix(8'd9, c, v);  chk("big_x9", 32'({v, c}), 32'h17);
        pix(8'd10, c, v); chk("big_x10", 32'({v, c}), 32'h00);
        sprite_large = 1'b0; sprite_enlarged = 1'b0;

        // Five sprites on one line: four shown, fifth flagged
        clear_sat();
        mem[int'(SPT) + 16] = 8'hFF;
        for (int k = 0; k < 5; k++) set_spr(k, 8'd9, 8'(50 + 10*k), 8'd2, 8'(k + 1));
        run_line(8'd10, cyc);
        chk("ovf_cyc", 32'(cyc), 32'd43);
        chk("ovf_nrd", 32'(rd_log.size()), 32'd21);
        chk("ovf_fifth", 32'(fifth), 32'd1);
        chk("ovf_fnum", 32'(fifth_num), 32'd4);
        pix(8'd50, c, v); chk("ovf_x50", 32'({v, c}), 32'h11);
        pix(8'd80, c, v); chk("ovf_x80", 32'({v, c}), 32'h14);
        pix(8'd90, c, v); chk("ovf_x90", 32'({v, c}), 32'h00);
        chk("ovf_coll", 32'(collision), 32'd0);
        clr_status();
        chk("ovf_clr", 32'(fifth), 32'd0);

        // status_clr lands on the same edge as the fifth-sprite set
        next_y = 8'd10;
        line_start = 1'b1; tick(); line_start = 1'b0;
        repeat (9) tick();
        chk("ovf_pre", 32'(fifth), 32'd0);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("ovf_setwins", 32'(fifth), 32'd1);
        cyc = 0;
        while (busy && cyc < 400) begin cyc++; tick(); end
        chk("ovf2_done", 32'(busy), 32'd0);
        clr_status();

        // Terminator at entry 2 with two hits
        clear_sat();
        set_spr(0, 8'd9, 8'd30, 8'd1, 8'd3);
        set_spr(1, 8'd9, 8'd60, 8'd1, 8'd4);
        run_line(8'd10, cyc);
        chk("term_cyc", 32'(cyc), 32'd23);
        chk("term_nrd", 32'(rd_log.size()), 32'd11);
        chk("term_fnum", 32'(fifth_num), 32'd2);
        chk("term_fifth", 32'(fifth), 32'd0);
        pix(8'd60, c, v); chk("term_x60", 32'({v, c}), 32'h14);

        // Transparent slot 0 under opaque slot 1: colour from slot 1, collision set
        chk("coll_pre", 32'(collision), 32'd0);
        clear_sat();
        mem[int'(SPT) + 24] = 8'h80;
        set_spr(0, 8'd9, 8'd100, 8'd3, 8'd0);
        set_spr(1, 8'd9, 8'd100, 8'd3, 8'd5);
        run_line(8'd10, cyc);
        pix(8'd100, c, v); chk("coll_x100", 32'({v, c}), 32'h15);
        chk("coll_set", 32'(collision), 32'd1);
        pix(8'd101, c, v); chk("coll_x101", 32'({v, c}), 32'h00);
        chk("coll_hold", 32'(collision), 32'd1);
        clr_status();
        chk("coll_clr", 32'(collision), 32'd0);

        // line_start mid-scan restarts the evaluation from scratch
        next_y = 8'd10;
        line_start = 1'b1; tick(); line_start = 1'b0;
        tick(); tick();
        run_line(8'd10, cyc);
        chk("abort_cyc", 32'(cyc), 32'd23);

        // Async reset in the middle of a scan
        x = 8'd100; pix_en = 1'b1;
        line_start = 1'b1; tick(); line_start = 1'b0;
        tick();
        chk("mid_pre_vld", 32'(pixel_valid), 32'd1);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rd", 32'(vif.vram_rd), 32'd0);
        chk("mid_vld", 32'(pixel_valid), 32'd0);
        #2;
        n_reset = 1'b1;
        tick();
        chk("mid_bank_cleared", 32'({pixel_valid, pixel_color}), 32'h00);
        pix_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
